// File: rtl/demux32_1to2_stream.sv
// demux32_1to2_stream: 1-to-2 valid/ready stream demultiplexer.
// Each destination (A, B) owns an independent 2-entry FIFO. inReady looks only
// at the FIFO picked by sel, so a full destination never stalls the other one.
// Optional build macro: DEMUX32_XFER_COUNT_EN adds 16-bit per-destination
// output-transfer counters on ports cntA / cntB.
module demux32_1to2_stream #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] outA,
    output logic             outAValid,
    input  logic             outAReady,
    output logic [WIDTH-1:0] outB,
    output logic             outBValid,
    input  logic             outBReady
`ifdef DEMUX32_XFER_COUNT_EN
    ,
    output logic [15:0]      cntA,
    output logic [15:0]      cntB
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } fifo_state_e;

    // Index 0 is destination A, index 1 is destination B.
    fifo_state_e      state_q [2];
    fifo_state_e      state_d [2];
    logic [WIDTH-1:0] head_q  [2];
    logic [WIDTH-1:0] head_d  [2];
    logic [WIDTH-1:0] tail_q  [2];
    logic [WIDTH-1:0] tail_d  [2];
    logic             valid   [2];
    logic             out_rdy [2];
    logic             wr      [2];
    logic             rd      [2];

    // Handshake decode: acceptance depends only on the selected FIFO's fill level.
    always_comb begin
        out_rdy[0] = outAReady;
        out_rdy[1] = outBReady;
        inReady    = (state_q[sel] != ST_TWO);
        for (int unsigned d = 0; d < 2; d++) begin
            valid[d] = (state_q[d] != ST_EMPTY);
            wr[d]    = inValid && inReady && (sel == 1'(d));
            rd[d]    = valid[d] && out_rdy[d];
        end
    end

    // Head is exposed only while the FIFO holds data; an empty FIFO shows zero.
    always_comb begin
        outAValid = valid[0];
        outBValid = valid[1];
        outA      = valid[0] ? head_q[0] : '0;
        outB      = valid[1] ? head_q[1] : '0;
    end

    // Per-FIFO next state: a write into a full FIFO cannot happen because
    // inReady is low for that destination.
    always_comb begin
        for (int unsigned d = 0; d < 2; d++) begin
            state_d[d] = state_q[d];
            head_d[d]  = head_q[d];
            tail_d[d]  = tail_q[d];
            case (state_q[d])
                ST_EMPTY: begin
                    if (wr[d]) begin
                        state_d[d] = ST_ONE;
                        head_d[d]  = in;
                    end
                end
                ST_ONE: begin
                    if (wr[d] && rd[d]) begin
                        head_d[d]  = in;
                    end else if (wr[d]) begin
                        state_d[d] = ST_TWO;
                        tail_d[d]  = in;
                    end else if (rd[d]) begin
                        state_d[d] = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (rd[d]) begin
                        state_d[d] = ST_ONE;
                        head_d[d]  = tail_q[d];
                    end
                end
                default: state_d[d] = ST_EMPTY;
            endcase
        end
    end

    // FIFO storage and state registers, cleared asynchronously.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned d = 0; d < 2; d++) begin
                state_q[d] <= ST_EMPTY;
                head_q[d]  <= '0;
                tail_q[d]  <= '0;
            end
        end else begin
            for (int unsigned d = 0; d < 2; d++) begin
                state_q[d] <= state_d[d];
                head_q[d]  <= head_d[d];
                tail_q[d]  <= tail_d[d];
            end
        end
    end

`ifdef DEMUX32_XFER_COUNT_EN
    logic [15:0] cnt_q [2];
    logic [15:0] cnt_d [2];

    // Count output transfers per destination; wraps naturally at 16 bits.
    always_comb begin
        for (int unsigned d = 0; d < 2; d++) begin
            cnt_d[d] = cnt_q[d] + 16'(rd[d]);
        end
    end

    // Counter registers, cleared asynchronously.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned d = 0; d < 2; d++) begin
                cnt_q[d] <= '0;
            end
        end else begin
            for (int unsigned d = 0; d < 2; d++) begin
                cnt_q[d] <= cnt_d[d];
            end
        end
    end

    assign cntA = cnt_q[0];
    assign cntB = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux32_1to2_stream.sv
// Testbench for demux32_1to2_stream: queue-based reference model plus directed
// literal scenarios and a randomized phase.
module tb_demux32_1to2_stream;

    localparam int W = 32;

    logic         Clk;
    logic         Reset;
    logic [W-1:0] in;
    logic         sel;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] outA;
    logic         outAValid;
    logic         outAReady;
    logic [W-1:0] outB;
    logic         outBValid;
    logic         outBReady;
`ifdef DEMUX32_XFER_COUNT_EN
    logic [15:0]  cntA;
    logic [15:0]  cntB;
`endif

    demux32_1to2_stream #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in        (in),
        .sel       (sel),
        .inValid   (inValid),
        .inReady   (inReady),
        .outA      (outA),
        .outAValid (outAValid),
        .outAReady (outAReady),
        .outB      (outB),
        .outBValid (outBValid),
        .outBReady (outBReady)
`ifdef DEMUX32_XFER_COUNT_EN
        ,
        .cntA      (cntA),
        .cntB      (cntB)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue per destination plus transfer counts.
    logic [W-1:0] qa [$];
    logic [W-1:0] qb [$];
    int unsigned  cnta = 0;
    int unsigned  cntb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                         input logic ra, input logic rb);
        inValid   = v;
        sel       = s;
        in        = d;
        outAReady = ra;
        outBReady = rb;
    endtask

    // One clock: compare DUT against the model at the falling edge, then
    // advance the model with the transfers that the rising edge performs.
    task automatic step();
        logic exp_rdy, acc, pa, pb;
        @(negedge Clk);
        exp_rdy = sel ? (qb.size() != 2) : (qa.size() != 2);
        chk("inReady",   {31'd0, inReady},   {31'd0, exp_rdy});
        chk("outAValid", {31'd0, outAValid}, {31'd0, qa.size() > 0});
        chk("outBValid", {31'd0, outBValid}, {31'd0, qb.size() > 0});
        chk("outA", outA, (qa.size() > 0) ? qa[0] : '0);
        chk("outB", outB, (qb.size() > 0) ? qb[0] : '0);
`ifdef DEMUX32_XFER_COUNT_EN
        chk("cntA", {16'd0, cntA}, {16'd0, cnta[15:0]});
        chk("cntB", {16'd0, cntB}, {16'd0, cntb[15:0]});
`endif
        acc = inValid && exp_rdy;
        pa  = (qa.size() > 0) && outAReady;
        pb  = (qb.size() > 0) && outBReady;
        @(posedge Clk);
        if (pa) begin void'(qa.pop_front()); cnta++; end
        if (pb) begin void'(qb.pop_front()); cntb++; end
        if (acc) begin
            if (sel) qb.push_back(in);
            else     qa.push_back(in);
        end
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2 Reset = 1'b0;
        #1;
        chk("rst_outAValid", {31'd0, outAValid}, 32'd0);
        chk("rst_outBValid", {31'd0, outBValid}, 32'd0);
        chk("rst_outA", outA, 32'd0);
        chk("rst_outB", outB, 32'd0);
        qa.delete();
        qb.delete();
        cnta = 0;
        cntb = 0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("rst_inReady", {31'd0, inReady}, 32'd1);
    endtask

    initial begin
        Reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("init_outAValid", {31'd0, outAValid}, 32'd0);
        chk("init_outBValid", {31'd0, outBValid}, 32'd0);
        chk("init_outA", outA, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Single route to B.
        drive(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        step();
        chk("r30_bvalid", {31'd0, outBValid}, 32'd1);
        chk("r30_outB", outB, 32'hDEADBEEF);
        chk("r30_avalid", {31'd0, outAValid}, 32'd0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step();
        chk("r30_bvalid_once", {31'd0, outBValid}, 32'd0);

        // Fill A, then drain.
        do_reset();
        drive(1'b1, 1'b0, 32'h1, 1'b0, 1'b0); #1 chk("r31_rdy1", {31'd0, inReady}, 32'd1); step();
        drive(1'b1, 1'b0, 32'h2, 1'b0, 1'b0); #1 chk("r31_rdy2", {31'd0, inReady}, 32'd1); step();
        drive(1'b1, 1'b0, 32'h3, 1'b0, 1'b0); #1 chk("r31_rdy3", {31'd0, inReady}, 32'd0); step();
        drive(1'b1, 1'b0, 32'h3, 1'b1, 1'b0); #1
        chk("r31_rdy_full", {31'd0, inReady}, 32'd0);
        chk("r31_outA1", outA, 32'h1);
        step();
        #1 chk("r31_rdy_after", {31'd0, inReady}, 32'd1);
        chk("r31_outA2", outA, 32'h2);
        step();
        chk("r31_outA3", outA, 32'h3);

        // Independence: A full, B still accepts.
        do_reset();
        drive(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0); step();
        drive(1'b1, 1'b1, 32'h55, 1'b0, 1'b0); #1
        chk("r32_rdy", {31'd0, inReady}, 32'd1);
        step();
        chk("r32_outB", outB, 32'h55);
        chk("r32_bvalid", {31'd0, outBValid}, 32'd1);
        chk("r32_outA_held", outA, 32'hA1);

        // Simultaneous read and write in state ONE.
        do_reset();
        drive(1'b1, 1'b0, 32'h10, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 32'h20, 1'b1, 1'b0); step();
        chk("r33_outA", outA, 32'h20);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0); step();
        chk("r33_one_left", {31'd0, outAValid}, 32'd0);

        // Mid-operation reset with both FIFOs full; do_reset checks outputs clear.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'(i % 2), 32'h100 + 32'(i), 1'b0, 1'b0);
            step();
        end
        chk("r34_pre_a", {31'd0, outAValid}, 32'd1);
        do_reset();

        // Randomized traffic in phases of varying sink readiness.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                drive(($urandom % 4) != 0, 1'($urandom % 2), $urandom,
                      ($urandom % 4) < 1 + ph, ($urandom % 4) < 3 - ph);
                step();
            end
        end

`ifdef DEMUX32_XFER_COUNT_EN
        // Counter wrap: 65537 transfers on A.
        do_reset();
        for (int i = 0; i < 70000 && cnta < 65537; i++) begin
            drive(cnta < 65536, 1'b0, $urandom, 1'b1, 1'b0);
            step();
        end
        chk("r35_count_reached", cnta, 32'd65537);
        chk("r35_cntA", {16'd0, cntA}, 32'h0001);
        chk("r35_cntB", {16'd0, cntB}, 32'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
